// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared lane/word widths, FSM encoding and int8 lane helpers
package cnn_pkg;

  localparam int LANE_W = 8;
  localparam int WORD_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } state_e;

  function automatic logic [LANE_W-1:0] lane_slice(input logic [WORD_W-1:0] w, input int idx);
    return w[idx*LANE_W +: LANE_W];
  endfunction

  function automatic logic [LANE_W-1:0] smax8(input logic [LANE_W-1:0] a, input logic [LANE_W-1:0] b);
    return ($signed(a) > $signed(b)) ? a : b;
  endfunction

  function automatic logic [LANE_W-1:0] relu8(input logic [LANE_W-1:0] x);
    return x[LANE_W-1] ? '0 : x;
  endfunction

endpackage

// File: rtl/lane_max8.sv
// rtl/lane_max8.sv - combinational per-lane signed int8 max of two packed words
module lane_max8
  import cnn_pkg::*;
#(
  parameter int LANES = 8
) (
  input  logic [WORD_W-1:0] a_i,
  input  logic [WORD_W-1:0] b_i,
  output logic [WORD_W-1:0] y_o
);

  always_comb begin
    y_o = '0;
    for (int i = 0; i < LANES; i++) begin
      y_o[i*LANE_W +: LANE_W] = smax8(lane_slice(a_i, i), lane_slice(b_i, i));
    end
  end

endmodule

// File: rtl/pool2x2_stage.sv
// rtl/pool2x2_stage.sv - 2x2/stride-2 int8 max pooling with optional ReLU over one feature bank
module pool2x2_stage
  import cnn_pkg::*;
#(
  parameter int IN_W   = 24,
  parameter int IN_H   = 24,
  parameter int ADDR_W = 12,
  parameter int LANES  = 8,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              relu_en,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rd_addr_a,
  output logic [ADDR_W-1:0] rd_addr_b,
  input  logic [WORD_W-1:0] rd_data_a,
  input  logic [WORD_W-1:0] rd_data_b,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WORD_W-1:0] wr_data
);

  localparam logic [ADDR_W-1:0] ROW_STEP   = ADDR_W'(IN_W);
  localparam logic [ADDR_W-1:0] LAST_COL   = ADDR_W'(IN_W - 2);
  localparam logic [ADDR_W-1:0] LAST_ROW   = ADDR_W'((IN_H - 2) * IN_W);
  localparam logic [1:0]        DRAIN_LAST = 2'(RD_LAT);

  state_e            state_q, state_d;
  logic              relu_q, relu_d;
  logic [ADDR_W-1:0] row_q, row_d;       // row base address, r*IN_W
  logic [ADDR_W-1:0] col_q, col_d;
  logic              phase_q, phase_d;
  logic [ADDR_W-1:0] addr_a_q, addr_a_d;
  logic [ADDR_W-1:0] addr_b_q, addr_b_d;
  logic              iss_v_q, iss_v_d;
  logic              iss_p_q, iss_p_d;
  logic [1:0]        drain_q, drain_d;
  logic [ADDR_W-1:0] nrow, ncol;

  logic [RD_LAT-1:0] tag_v_q, tag_p_q;
  logic              ret_v, ret_p;
  logic [WORD_W-1:0] hold_q, pair_max, quad_max, pooled;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q, out_cnt_q;
  logic [WORD_W-1:0] wr_data_q;

  always_comb begin
    state_d  = state_q;
    relu_d   = relu_q;
    row_d    = row_q;
    col_d    = col_q;
    phase_d  = phase_q;
    addr_a_d = addr_a_q;
    addr_b_d = addr_b_q;
    iss_v_d  = 1'b0;
    iss_p_d  = 1'b0;
    drain_d  = drain_q;
    nrow     = row_q;
    ncol     = col_q + ADDR_W'(2);
    if (col_q == LAST_COL) begin
      ncol = '0;
      nrow = row_q + (ROW_STEP << 1);
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_READ;
          relu_d   = relu_en;
          row_d    = '0;
          col_d    = '0;
          phase_d  = 1'b0;
          addr_a_d = '0;
          addr_b_d = ROW_STEP;
          iss_v_d  = 1'b1;
        end
      end
      ST_READ: begin
        if (!phase_q) begin
          phase_d  = 1'b1;
          addr_a_d = row_q + col_q + ADDR_W'(1);
          addr_b_d = row_q + ROW_STEP + col_q + ADDR_W'(1);
          iss_v_d  = 1'b1;
          iss_p_d  = 1'b1;
        end else if (row_q == LAST_ROW && col_q == LAST_COL) begin
          state_d = ST_DRAIN;
          drain_d = '0;
        end else begin
          row_d    = nrow;
          col_d    = ncol;
          phase_d  = 1'b0;
          addr_a_d = nrow + ncol;
          addr_b_d = nrow + ROW_STEP + ncol;
          iss_v_d  = 1'b1;
        end
      end
      // RD_LAT+1 cycles lets the last phase-1 return land in wr_data before FIN
      ST_DRAIN: begin
        if (drain_q == DRAIN_LAST) state_d = ST_FIN;
        else drain_d = drain_q + 2'd1;
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign ret_v = tag_v_q[RD_LAT-1];
  assign ret_p = tag_p_q[RD_LAT-1];

  lane_max8 #(.LANES(LANES)) u_pair_max (.a_i(rd_data_a), .b_i(rd_data_b), .y_o(pair_max));
  lane_max8 #(.LANES(LANES)) u_quad_max (.a_i(hold_q),    .b_i(pair_max),  .y_o(quad_max));

  always_comb begin
    pooled = quad_max;
    if (relu_q) begin
      for (int i = 0; i < LANES; i++) begin
        pooled[i*LANE_W +: LANE_W] = relu8(lane_slice(quad_max, i));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      relu_q    <= 1'b0;
      row_q     <= '0;
      col_q     <= '0;
      phase_q   <= 1'b0;
      addr_a_q  <= '0;
      addr_b_q  <= '0;
      iss_v_q   <= 1'b0;
      iss_p_q   <= 1'b0;
      drain_q   <= '0;
      tag_v_q   <= '0;
      tag_p_q   <= '0;
      hold_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      out_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      relu_q   <= relu_d;
      row_q    <= row_d;
      col_q    <= col_d;
      phase_q  <= phase_d;
      addr_a_q <= addr_a_d;
      addr_b_q <= addr_b_d;
      iss_v_q  <= iss_v_d;
      iss_p_q  <= iss_p_d;
      drain_q  <= drain_d;
      tag_v_q[0] <= iss_v_q;
      tag_p_q[0] <= iss_p_q;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_v_q[i] <= tag_v_q[i-1];
        tag_p_q[i] <= tag_p_q[i-1];
      end
      if (ret_v && !ret_p) hold_q <= pair_max;
      wr_en_q <= ret_v && ret_p;
      if (ret_v && ret_p) begin
        wr_data_q <= pooled;
        wr_addr_q <= out_cnt_q;
        out_cnt_q <= out_cnt_q + ADDR_W'(1);
      end else if (state_q == ST_IDLE && start) begin
        out_cnt_q <= '0;
      end
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_FIN);
  assign rd_addr_a = addr_a_q;
  assign rd_addr_b = addr_b_q;
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;

endmodule
